// File: rtl/instr_queue_pkg.sv
// Shared processor constants used by the fetch/decode instruction queue.
// Holds the NOP encoding and the default queue depth.
package instr_queue_pkg;

    localparam int          IQ_DEFAULT_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Occupancy must be able to represent both 0 and DEPTH.
    function automatic int iq_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle for instr_queue.
// The queue uses the slave view; fetch/decode logic uses the master view.
interface instr_queue_if
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEFAULT_DEPTH,
    parameter int WIDTH = 32
);
    localparam int CW = iq_count_width(DEPTH);

    logic             in_valid;
    logic [WIDTH-1:0] in_instr;
    logic [WIDTH-1:0] in_pc;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, count
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, count
    );

endinterface

// File: rtl/instr_queue_mem.sv
// Entry storage for instr_queue: one synchronous write port and one
// asynchronous read port so the head entry is visible without a cycle of delay.
module instr_queue_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Contents are never reset; validity is tracked by the queue's count.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: a small circular FIFO of
// {instr, pc} pairs with flush-on-redirect and an asynchronous start-up reset.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEFAULT_DEPTH,
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          start_up_n,
    instr_queue_if.slave  q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = iq_count_width(DEPTH);

    logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               full, empty;
    logic               push, pop;
    logic [2*WIDTH-1:0] wr_entry;
    logic [2*WIDTH-1:0] head_entry;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Handshake depends only on stored occupancy, never on out_ready.
    assign q.in_ready  = !full;
    assign q.out_valid = !empty;
    assign q.count     = count_reg;

    // A redirect kills both directions in the same cycle.
    assign push = q.in_valid  && !full  && !q.flush;
    assign pop  = q.out_ready && !empty && !q.flush;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (q.flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            // Power-of-two depth: natural overflow gives the modulo wrap.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge start_up_n) begin
        if (!start_up_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign wr_entry = {q.in_instr, q.in_pc};

    instr_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (2*WIDTH),
        .ADDR_W (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_entry)
    );

    // Decode sees a NOP whenever the queue is empty, including during reset.
    assign q.out_instr = q.out_valid ? head_entry[2*WIDTH-1:WIDTH] : WIDTH'(NOP_INSTR);
    assign q.out_pc    = q.out_valid ? head_entry[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue: fill/drain, concurrent
// push/pop across pointer wrap, flush priority, full-with-pop, async reset.
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic clk;
    logic start_up_n;
    int   total;
    int   bad;

    instr_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .start_up_n (start_up_n),
        .q          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = instr_of(pc);
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        start_up_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_count", 32'(bus.count), 32'd0);
        tick();
        tick();
        @(negedge clk);
        start_up_n = 1'b1;

        // Fill with out_ready low; no same-cycle bypass
        drive(1'b1, 32'h00, 1'b0, 1'b0);
        #1;
        check("nobypass_valid", 32'(bus.out_valid), 32'd0);
        check("nobypass_instr", bus.out_instr, 32'h0);
        tick();
        check("lat1_valid", 32'(bus.out_valid), 32'd1);
        check("lat1_pc", bus.out_pc, 32'h00);
        check("lat1_instr", bus.out_instr, instr_of(32'h00));
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        check("full_count", 32'(bus.count), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        check("fifth_count", 32'(bus.count), 32'd4);
        check("fifth_head", bus.out_pc, 32'h00);

        // Drain in order
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", bus.out_pc, 32'(i * 4));
            check("drain_instr", bus.out_instr, instr_of(32'(i * 4)));
            tick();
        end
        check("drained_valid", 32'(bus.out_valid), 32'd0);
        check("drained_instr", bus.out_instr, 32'h0);
        check("drained_pc", bus.out_pc, 32'h0);
        tick();
        check("empty_pop_count", 32'(bus.count), 32'd0);

        // Simultaneous push/pop at count=2, 12 words across pointer wraps
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h200 + 32'(k * 4), 1'b0, 1'b0);
            tick();
        end
        check("pp_pre_count", 32'(bus.count), 32'd2);
        for (int k = 2; k < 14; k++) begin
            drive(1'b1, 32'h200 + 32'(k * 4), 1'b1, 1'b0);
            #1;
            check("pp_head", bus.out_pc, 32'h200 + 32'((k - 2) * 4));
            tick();
            check("pp_count", 32'(bus.count), 32'd2);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("pp_tail0", bus.out_pc, 32'h230);
        tick();
        check("pp_tail1", bus.out_pc, 32'h234);
        check("pp_tail1_instr", bus.out_instr, instr_of(32'h234));
        tick();
        check("pp_empty", 32'(bus.out_valid), 32'd0);

        // Flush with push at count=3
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h300 + 32'(k * 4), 1'b0, 1'b0);
            tick();
        end
        check("fl_pre_count", 32'(bus.count), 32'd3);
        drive(1'b1, 32'h30C, 1'b1, 1'b1);
        tick();
        check("fl_count", 32'(bus.count), 32'd0);
        check("fl_valid", 32'(bus.out_valid), 32'd0);
        check("fl_pc", bus.out_pc, 32'h0);
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        check("fl_next_count", 32'(bus.count), 32'd1);
        check("fl_next_pc", bus.out_pc, 32'h40);
        check("fl_next_instr", bus.out_instr, instr_of(32'h40));

        // Full plus pop plus push: only the pop happens
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 32'h40 + 32'(k * 4), 1'b0, 1'b0);
            tick();
        end
        check("fpp_full", 32'(bus.count), 32'd4);
        drive(1'b1, 32'h50, 1'b1, 1'b0);
        #1;
        check("fpp_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("fpp_count", 32'(bus.count), 32'd3);
        check("fpp_head", bus.out_pc, 32'h44);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("fpp_drain", bus.out_pc, 32'h44 + 32'(k * 4));
            tick();
        end
        check("fpp_no_extra", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset mid-cycle at count=2
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h60 + 32'(k * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("ar_pre_count", 32'(bus.count), 32'd2);
        #2;
        start_up_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'd0);
        check("ar_count", 32'(bus.count), 32'd0);
        check("ar_pc", bus.out_pc, 32'h0);
        check("ar_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        @(negedge clk);
        start_up_n = 1'b1;
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        check("ar_push_count", 32'(bus.count), 32'd1);
        check("ar_push_pc", bus.out_pc, 32'h100);

        // Fetch pairing: word fetched alongside a taken branch never reaches decode
        drive(1'b1, 32'h500, 1'b1, 1'b1);
        tick();
        check("br_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 32'h600, 1'b0, 1'b0);
        tick();
        check("br_target_pc", bus.out_pc, 32'h600);
        check("br_count", 32'(bus.count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
